// File: rtl/sort_chain_ctrl.sv
// Host-side feed/drain controller for the sequence-sorter comparator chain.
// Define SORT_DESCEND_EN to replay each sorted batch in descending order.
module sort_chain_ctrl #(
  parameter int unsigned DW  = 8,
  parameter int unsigned N   = 4,
  parameter int unsigned LAT = N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] chain_in,
  output logic          chain_clr,
  input  logic [DW-1:0] chain_out,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] LastCnt  = CW'(N - 1);
  localparam logic [CW-1:0] One      = CW'(1);
  localparam logic [DW-1:0] Sentinel = {DW{1'b1}};

`ifdef SORT_DESCEND_EN
  localparam bit Descend = 1'b1;
`else
  localparam bit Descend = 1'b0;
`endif

  typedef enum logic [2:0] {
    StLoad,
    StFlush,
    StDrain,
    StOut,
    StClear
  } state_e;

  state_e        state_q;
  logic [CW-1:0] load_cnt_q;
  logic [CW-1:0] sent_cnt_q;
  logic [CW-1:0] cap_cnt_q;
  logic [CW-1:0] rd_idx_q;
  logic          sent_q;
  logic [LAT-1:0] tag_q;
  logic [DW-1:0] buffer_q [N];

  logic          capture;
  logic          cap_last;
  logic [CW-1:0] rd_next;
  logic [IW-1:0] first_pos;

  // Buffer slot read for the rd_idx-th output word.
  function automatic logic [IW-1:0] rd_pos(input logic [CW-1:0] idx);
    if (Descend) begin
      return IW'(LastCnt - idx);
    end
    return idx[IW-1:0];
  endfunction

  // The tag pipeline mirrors the chain, so its tail marks a drained word on chain_out.
  assign capture   = tag_q[LAT-1] & ((state_q == StFlush) | (state_q == StDrain));
  assign cap_last  = capture & (cap_cnt_q == LastCnt);
  assign rd_next   = rd_idx_q + One;
  assign first_pos = rd_pos('0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      in_ready   <= 1'b1;
      chain_in   <= '0;
      chain_clr  <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      load_cnt_q <= '0;
      sent_cnt_q <= '0;
      cap_cnt_q  <= '0;
      rd_idx_q   <= '0;
      sent_q     <= 1'b0;
      tag_q      <= '0;
      for (int i = 0; i < N; i++) begin
        buffer_q[i] <= '0;
      end
    end else begin
      chain_in  <= '0;
      chain_clr <= 1'b0;
      sent_q    <= 1'b0;
      tag_q[0]  <= sent_q;
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end

      if (capture) begin
        buffer_q[cap_cnt_q[IW-1:0]] <= chain_out;
        cap_cnt_q                   <= cap_cnt_q + One;
      end

      unique case (state_q)
        StLoad: begin
          if (in_valid && in_ready) begin
            chain_in   <= in_data;
            busy       <= 1'b1;
            load_cnt_q <= load_cnt_q + One;
            if (load_cnt_q == LastCnt) begin
              state_q  <= StFlush;
              in_ready <= 1'b0;
            end
          end
        end

        StFlush: begin
          chain_in   <= Sentinel;
          sent_q     <= 1'b1;
          sent_cnt_q <= sent_cnt_q + One;
          if (sent_cnt_q == LastCnt) begin
            state_q <= StDrain;
          end
        end

        StDrain: begin
          if (cap_last) begin
            state_q   <= StOut;
            out_valid <= 1'b1;
            out_last  <= (N == 1);
            // The slot being written this edge is not in the buffer yet.
            if (first_pos == IW'(N - 1)) begin
              out_data <= chain_out;
            end else begin
              out_data <= buffer_q[first_pos];
            end
          end
        end

        StOut: begin
          if (out_valid && out_ready) begin
            if (rd_idx_q == LastCnt) begin
              state_q   <= StClear;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              chain_clr <= 1'b1;
            end else begin
              rd_idx_q <= rd_next;
              out_data <= buffer_q[rd_pos(rd_next)];
              out_last <= (rd_next == LastCnt);
            end
          end
        end

        StClear: begin
          state_q    <= StLoad;
          in_ready   <= 1'b1;
          busy       <= 1'b0;
          load_cnt_q <= '0;
          sent_cnt_q <= '0;
          cap_cnt_q  <= '0;
          rd_idx_q   <= '0;
          tag_q      <= '0;
        end

        default: begin
          state_q <= StLoad;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_chain_ctrl.sv
// Bench for sort_chain_ctrl: behavioural comparator chain plus an output scoreboard.
// Honours SORT_DESCEND_EN the same way the design does.
module tb_sort_chain_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned LAT = N;

  typedef logic [DW-1:0] word_t;
  typedef struct packed {
    word_t d;
    logic  l;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  word_t in_data;
  logic  in_valid;
  logic  in_ready;
  word_t chain_in;
  logic  chain_clr;
  word_t out_data;
  logic  out_valid;
  logic  out_ready;
  logic  out_last;
  logic  busy;

  word_t cout [N];
  word_t cin  [N];

  exp_t  exp_q [$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    clr_cnt = 0;
  int    last_hs_cyc = 0;
  bit    chk_load = 1'b0;
  bit    hold_pend = 1'b0;
  word_t hold_data = '0;
  logic  acc_q = 1'b0;
  word_t acc_d = '0;
  int    rdy_mode = 0;
  int    rdy_i = 0;

  always #5 clk = ~clk;

  sort_chain_ctrl #(
    .DW  (DW),
    .N   (N),
    .LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .chain_in  (chain_in),
    .chain_clr (chain_clr),
    .chain_out (cout[N-1]),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Comparator cells: keep the larger word, pass the smaller one on, one register per cell.
  assign cin[0] = chain_in;
  for (genvar k = 1; k < N; k++) begin : g_link
    assign cin[k] = cout[k-1];
  end

  for (genvar k = 0; k < N; k++) begin : g_cell
    word_t st;
    word_t ot;
    assign cout[k] = ot;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st <= '0;
        ot <= '0;
      end else if (chain_clr) begin
        st <= '0;
        ot <= '0;
      end else if (cin[k] > st) begin
        st <= cin[k];
        ot <= st;
      end else begin
        ot <= cin[k];
      end
    end
  end

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_last"}, 32'(out_last), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_chain_in"}, 32'(chain_in), 0);
    check({tag, "_chain_clr"}, 32'(chain_clr), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Cycle count and the handshake seen at each rising edge.
  initial forever begin
    @(posedge clk);
    cyc   = cyc + 1;
    acc_q = in_valid && in_ready;
    acc_d = in_data;
  end

  initial forever begin
    @(posedge clk);
    #1;
    rdy_i++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((rdy_i % 4) == 0) || ((rdy_i % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor, sampled on the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(hold_data));
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_last", 32'(out_last), 32'(e.l));
          if (e.l) last_hs_cyc = cyc;
        end
      end
      if (chain_clr) begin
        clr_cnt++;
        check("clr_chain_in", 32'(chain_in), 0);
      end
      if (chk_load) check("load_chain_in", 32'(chain_in), acc_q ? 32'(acc_d) : 0);
    end
  end

  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic feed(input word_t w);
    int g = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("feed_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_batch(input word_t w [N], input int gap, input int mode);
    word_t s [N];
    word_t t;
    exp_t  e;
    int    t0;
    int    clr0;
    int    guard;
    rdy_mode = mode;
    s = w;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N - 1 - i; j++) begin
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
`ifdef SORT_DESCEND_EN
      e.d = s[N-1-i];
`else
      e.d = s[i];
`endif
      e.l = (i == N - 1);
      exp_q.push_back(e);
    end
    clr0 = clr_cnt;
    chk_load = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i > 0) begin
        repeat (gap) @(posedge clk);
        @(negedge clk);
      end
      feed(w[i]);
    end
    chk_load = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 0);
    t0 = cyc;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    // Nth word on chain_in, then N sentinels, LAT-cycle chain, N captures.
    check("cap_latency", cyc - t0, 32'(LAT + N + 1));
    check("busy_out", 32'(busy), 1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", exp_q.size(), 0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 20);
    check("turnaround", cyc - last_hs_cyc, 2);
    check("clr_pulses", clr_cnt - clr0, 1);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    word_t rw [N];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_batch('{8'd5, 8'd3, 8'd9, 8'd1}, 0, 0);
    run_batch('{8'd5, 8'd3, 8'd9, 8'd1}, 0, 1);
    run_batch('{8'd7, 8'd7, 8'd0, 8'd255}, 0, 0);
    run_batch('{8'd5, 8'd3, 8'd9, 8'd1}, 2, 1);

    // Abort a batch one cycle into the sentinel flush.
    rdy_mode = 0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      feed(word_t'(8'd200 + 8'(i)));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_batch('{8'd4, 8'd2, 8'd8, 8'd6}, 0, 0);

    run_batch('{8'd5, 8'd3, 8'd9, 8'd1}, 0, 0);
    run_batch('{8'd2, 8'd2, 8'd2, 8'd2}, 0, 1);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) rw[k] = word_t'($urandom_range(0, 255));
      run_batch(rw, int'($urandom_range(0, 3)), 2);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sort_chain_ctrl.md
Name: sort_chain_ctrl

Overview:
- Controller on the host side of the sequence-sorter comparator chain. It takes a batch of N words on a valid/ready input stream, streams them into the head of the chain, then flushes the chain with sentinels.
- It captures the N drained words from the chain tail in ascending order, buffers them, and replays them on a valid/ready output stream.
- It is the feed/drain end of the interface that the comparator cells consume and produce.

Parameters:
DW, 8, data width (must match the chain).
N, 4, number of comparator cells, which is also the batch size.
LAT, N, chain latency in cycles from chain_in to chain_out (one register per cell).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_data  in  DW  batch word.
in_valid  in  1  in_data valid.
in_ready  out  1  block accepts in_data this cycle.
chain_in  out  DW  word driven into the chain head, registered.
chain_clr  out  1  clear/subtract strobe to all cells, registered.
chain_out  in  DW  word from the chain tail.
out_data  out  DW  sorted result word.
out_valid  out  1  out_data valid.
out_ready  in  1  consumer accepts out_data.
out_last  out  1  high with the final word of a batch.
busy  out  1  high in any state other than LOAD with zero words accepted.

Behaviour:
- Reset values: all outputs 0 except in_ready=1; state=LOAD; all counters 0; tag pipeline cleared.
- The chain has no enable and advances every cycle. When no word is issued, chain_in is driven 0; 0 never displaces a stored maximum.
- Sentinel value is all-ones {DW{1'b1}}.
- LOAD:
  - in_ready=1. On in_valid & in_ready, chain_in<=in_data next cycle and the load count increments.
  - On the Nth accept, go to FLUSH, and in_ready drops in the same edge.
- FLUSH:
  - Issue N sentinels, one per cycle, on consecutive cycles.
  - Each sentinel pushes a 1 into the LAT-deep tag shift register; all other cycles push 0.
  - After the Nth sentinel, go to DRAIN.
- DRAIN / capture:
  - Capture rule, applied in FLUSH and DRAIN: when the tag shift register output is 1, write chain_out into buffer[cap_cnt] and increment cap_cnt.
  - The first tagged capture occurs LAT cycles after the first sentinel is issued.
  - When cap_cnt reaches N, go to OUT.
- OUT:
  - out_valid=1 and out_data=buffer[rd_idx], registered.
  - rd_idx advances on out_valid & out_ready.
  - out_last=1 when rd_idx==N-1.
  - out_data and out_valid hold stable while out_ready=0.
  - On the last handshake, go to CLEAR.
- CLEAR:
  - chain_clr=1 for exactly one cycle, with chain_in=0.
  - Then reset all counters and return to LOAD with in_ready=1 on the following cycle.
- Minimum turnaround: a new batch can be accepted 1 cycle after the out_last handshake.
- Ties and all-ones data: equal values are legal and are emitted once per occurrence. A data word equal to the sentinel sorts last and is emitted correctly.
- in_valid outside LOAD is ignored and no word is consumed.
- Asynchronous reset mid-operation (any state): the block returns immediately to reset values and any partial batch is discarded. The chain is not cleared by this block; the system resets the chain from the same rst_n.
- Counter widths: $clog2(N+1) bits. No wrap occurs because every counter is reset in CLEAR.

Optional Feature:
- SORT_DESCEND_EN defined: OUT reads the buffer from rd_idx=N-1 down to 0, so results are in descending order. out_last is asserted with buffer[0].
- SORT_DESCEND_EN not defined: ascending order, buffer[0] to buffer[N-1].
- Capture and chain sequencing are identical in both builds.

Test Plan:
- DW=8, N=4, ascending build, in_data 5,3,9,1 streamed back-to-back with out_ready=1 -> out_data 1,3,5,9, out_last only on 9, then chain_clr pulses for exactly 1 cycle.
- Same batch with out_ready toggling 1,0,0,1,... -> no word dropped or duplicated, out_data stable during stalls, sequence 1,3,5,9.
- Ties and extremes: inputs 7,7,0,255 -> 0,7,7,255.
- in_valid gaps of 2 cycles between words in LOAD -> same sorted result; chain_in=0 on gap cycles; first tagged capture occurs exactly LAT cycles after the first sentinel.
- Assert rst_n=0 mid-FLUSH, release, then feed 4,2,8,6 -> 2,4,6,8, with no residue from the aborted batch.
- SORT_DESCEND_EN build, inputs 5,3,9,1 -> 9,5,3,1, out_last on 1. Then a back-to-back second batch 2,2,2,2 is accepted 1 cycle after the first out_last -> 2,2,2,2.
